// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
//
// UART receiver for 8N1 frames. An optional even-parity bit is added when the
// macro UART_RX_PARITY_EN is defined. The receiver is driven by a 16x
// oversample square wave (rx_clk) coming from the baud generator. It runs in
// the same clk domain.
//
// Each bit is the majority vote of the synchronized line at oversample ticks
// 7, 8 and 9. The FSM returns to IDLE at mid-stop, so back-to-back frames
// are accepted.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   rx_clk        16x oversample square wave; each rising edge is one tick
//   rx            serial input, idle high (asynchronous)
//   data_out      last good byte received; holds until the next good frame
//   data_valid    one-cycle pulse when data_out is updated
//   framing_error one-cycle pulse when the stop bit is voted low
//   parity_error  one-cycle pulse with data_valid on bad even parity
//                 (tied to 0 without UART_RX_PARITY_EN)
//   busy          high while the FSM is outside IDLE
// -----------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'd9;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic                 rx_clk_d_q;
    logic                 armed_q, armed_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;       // [0] = tick 7, [1] = tick 8
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_error_q, framing_error_d;
    logic                 tick;
    logic                 vote;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_error_q, parity_error_d;
`endif

    assign tick = rx_clk & ~rx_clk_d_q;
    // Tick-9 sample is taken live; ticks 7 and 8 were captured earlier.
    assign vote = (samp_q[0] & samp_q[1]) | (rx_s_q & (samp_q[0] | samp_q[1]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_clk_d_q      <= 1'b0;
            state_q         <= S_IDLE;
            armed_q         <= 1'b1;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            samp_q          <= '0;
            shreg_q         <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q       <= rx;
            rx_s_q          <= rx_meta_q;
            rx_clk_d_q      <= rx_clk;
            state_q         <= state_d;
            armed_q         <= armed_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            samp_q          <= samp_d;
            shreg_q         <= shreg_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= parity_bit_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        armed_d         = armed_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        samp_d          = samp_q;
        shreg_d         = shreg_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d    = parity_bit_q;
        parity_error_d  = 1'b0;
`endif
        if (tick) begin
            if (tick_cnt_q == 4'd7) samp_d[0] = rx_s_q;
            if (tick_cnt_q == 4'd8) samp_d[1] = rx_s_q;
            case (state_q)
                S_IDLE: begin
                    // A low line is a start only once the line was seen high
                    // after a framing error (break suppression).
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d    = S_START;
                        tick_cnt_d = 4'd1;
                    end
                end
                S_START: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_TICK && vote) begin
                        state_d    = S_IDLE;   // glitch, not a real start bit
                        tick_cnt_d = '0;
                    end else if (tick_cnt_q == LAST_TICK) begin
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_TICK)
                        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (tick_cnt_q == LAST_TICK) begin
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_TICK) parity_bit_d = vote;
                    if (tick_cnt_q == LAST_TICK) state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_TICK) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                        if (vote) begin
                            data_out_d   = shreg_q;
                            data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error_d = (^shreg_q) ^ parity_bit_q;
`endif
                        end else begin
                            framing_error_d = 1'b1;
                            armed_d         = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversample
//
// Drives serial frames aligned to the 16x oversample clock. A behavioural
// model predicts which bytes, framing errors and parity errors should appear.
// The model works per frame: each bit is voted from its samples at ticks
// 7..9, a byte is delivered when the stop bit votes high, and parity is even.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversample;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx_clk  = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_clk        (rx_clk),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    // 16 clk cycles per tick; edges offset from clk edges.
    initial begin
        #2;
        forever #80 rx_clk = ~rx_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- observed events ----------------
    logic [7:0] got_q[$];
    bit         got_pe_q[$];
    int         fe_cnt    = 0;
    int         stray_pe  = 0;
    int         busy_rise = 0;
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (data_valid) begin
                got_q.push_back(data_out);
                got_pe_q.push_back(parity_error);
                $display("rx byte 0x%02h parity_error=%0b", data_out, parity_error);
            end else if (parity_error) begin
                stray_pe++;
            end
            if (framing_error) begin
                fe_cnt++;
                $display("rx framing_error");
            end
            if (busy && !busy_prev) busy_rise++;
            busy_prev = busy;
        end else begin
            busy_prev = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    bit         exp_pe_q[$];
    int         exp_fe    = 0;
    logic [7:0] last_byte = 8'h00;

    function automatic bit vote3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    // Holds one bit for 16 ticks; if flip is set the value is inverted for
    // tick 8 only. Returns the value the model expects from the vote.
    task automatic send_bit(input bit b, input bit flip, output bit voted);
        bit s7, s8, s9;
        s7 = b; s8 = flip ? ~b : b; s9 = b;
        rx = b;  ticks(8);
        rx = s8; ticks(1);
        rx = b;  ticks(7);
        voted = vote3(s7, s8, s9);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit pbit,
                              input int glitch_bit);
        bit v, pv, sv;
        logic [7:0] rcv;
        rcv = '0;
        send_bit(1'b0, 1'b0, v);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], i == glitch_bit, v);
            rcv[i] = v;
        end
        pv = 1'b0;
`ifdef UART_RX_PARITY_EN
        send_bit(pbit, 1'b0, pv);
`endif
        send_bit(stop_b, 1'b0, sv);
        if (sv) begin
            exp_q.push_back(rcv);
`ifdef UART_RX_PARITY_EN
            exp_pe_q.push_back((^rcv) ^ pv);
`else
            exp_pe_q.push_back(1'b0);
`endif
            last_byte = rcv;
        end else begin
            exp_fe++;
        end
    endtask

    function automatic bit even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic verify(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, got_q[i], exp_q[i]);
            check({tag, "_perr"}, got_pe_q[i], exp_pe_q[i]);
        end
        check({tag, "_ferr"}, fe_cnt, exp_fe);
        check({tag, "_stray_perr"}, stray_pe, 0);
        check({tag, "_data_out"}, data_out, last_byte);
        got_q.delete(); got_pe_q.delete(); exp_q.delete(); exp_pe_q.delete();
        fe_cnt = 0; exp_fe = 0; stray_pe = 0; busy_rise = 0;
    endtask

    initial begin
        bit v;
        logic [7:0] d;
        int gap;
        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_framing_error", framing_error, 1'b0);
        check("rst_parity_error", parity_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        ticks(2);
        reset_n = 1'b1;
        ticks(2);

        // 0x55, busy low after mid-stop
        send_frame(8'h55, 1'b1, even_par(8'h55), -1);
        check("x55_busy_after_stop", busy, 1'b0);
        verify("x55");

        // back-to-back 0x00, 0xFF
        send_frame(8'h00, 1'b1, even_par(8'h00), -1);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), -1);
        ticks(4);
        verify("b2b");

        // start glitch: low 4 ticks then high
        rx = 1'b0; ticks(4);
        rx = 1'b1; ticks(3);
        check("glitch_busy_mid", busy, 1'b1);
        ticks(8);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_busy_pulses", busy_rise, 1);
        verify("glitch");
        ticks(16);

        // framing error, held break, then recovery
        send_frame(8'hA3, 1'b0, even_par(8'hA3), -1);
        rx = 1'b0; ticks(48);
        check("break_busy", busy, 1'b0);
        check("break_starts", busy_rise, 1);
        check("break_data_out", data_out, last_byte);
        rx = 1'b1; ticks(16);
        send_frame(8'h3C, 1'b1, even_par(8'h3C), -1);
        ticks(4);
        verify("ferr");

        // majority vote corrects bit 2 disturbed only at tick 8
        send_frame(8'h96, 1'b1, even_par(8'h96), 2);
        ticks(4);
        verify("vote");

        // reset mid-frame (DATA bit 4), then 0x5A
        d = 8'hC9;
        send_bit(1'b0, 1'b0, v);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0, v);
        rx = d[4]; ticks(8);
        check("midrst_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_data_valid", data_valid, 1'b0);
        check("midrst_framing_error", framing_error, 1'b0);
        check("midrst_parity_error", parity_error, 1'b0);
        check("midrst_busy", busy, 1'b0);
        last_byte = 8'h00;
        rx = 1'b1;
        ticks(2);
        reset_n = 1'b1;
        ticks(16);
        send_frame(8'h5A, 1'b1, even_par(8'h5A), -1);
        ticks(4);
        verify("midrst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1);
        ticks(4);
        verify("parity_bad");
`endif

        // randomized frames with random gaps, stop and parity faults
        for (int k = 0; k < 6; k++) begin
            bit sb, pb;
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            pb = even_par(d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, sb, pb, -1);
            gap = sb ? $urandom_range(0, 12) : $urandom_range(2, 12);
            rx = 1'b1;
            ticks(gap);
        end
        ticks(4);
        verify("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
